decoder_2to4: RTL and testbench

Registered 2-to-4 line decoder with active-high enable. Drives exactly one of four select lines high for the binary code on `A` while enabled, and all lines inactive otherwise. Used as a select/chip-enable generator for four downstream targets. Outputs are registered so consumers see glitch-free, clock-aligned selects.

---
 rtl/decoder_2to4_if.sv | 36 +++
 rtl/decoder_2to4.sv | 57 +++++
 tb/tb_decoder_2to4.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_2to4_if.sv
// decoder_2to4_if
//   Groups the select code, enable and the four registered select lines
//   of the 2-to-4 decoder into one bundle.
//   Signals:
//     A[1:0]  binary select code, A[1] is the MSB
//     E       active-high enable
//     Y0..Y3  select lines for codes 2'b00..2'b11
//   Modports:
//     master  drives A/E, observes Y0..Y3 (the block issuing selects)
//     slave   observes A/E, drives Y0..Y3 (the decoder itself)
interface decoder_2to4_if;
  logic [1:0] A;
  logic       E;
  logic       Y0;
  logic       Y1;
  logic       Y2;
  logic       Y3;

  modport master (
    output A,
    output E,
    input  Y0,
    input  Y1,
    input  Y2,
    input  Y3
  );

  modport slave (
    input  A,
    input  E,
    output Y0,
    output Y1,
    output Y2,
    output Y3
  );
endinterface

// File: rtl/decoder_2to4.sv
// decoder_2to4
//   Registered 2-to-4 line decoder with active-high enable. While E is
//   high exactly one select line follows the code on A; otherwise all
//   lines are inactive. Outputs come straight from flops so downstream
//   chip-enables are glitch-free and clock aligned.
//   Parameters:
//     OUT_ACTIVE_LOW  0: selected line is 1; 1: all outputs inverted,
//                     including the reset value
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset, forces all lines inactive
//     bus     decoder_2to4_if.slave (A, E in; Y0..Y3 out)
module decoder_2to4 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_2to4_if.slave bus
);

  // Selects are held internally as active-high one-hot (or all-zero);
  // polarity is only applied at the ports so the one-hot invariant is
  // easy to reason about in a single place.
  logic [3:0] y_d;
  logic [3:0] y_q;
  logic [3:0] y_out;

  always_comb begin
    y_d = 4'b0000;
    if (bus.E) begin
      case (bus.A)
        2'b00:   y_d = 4'b0001;
        2'b01:   y_d = 4'b0010;
        2'b10:   y_d = 4'b0100;
        default: y_d = 4'b1000;
      endcase
    end
  end

  // The whole vector updates on one edge, so a change of A swaps the
  // active line without any cycle showing two lines asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 4'b0000;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_out  = OUT_ACTIVE_LOW ? ~y_q : y_q;

  assign bus.Y0 = y_out[0];
  assign bus.Y1 = y_out[1];
  assign bus.Y2 = y_out[2];
  assign bus.Y3 = y_out[3];

endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4
//   Directed bench for decoder_2to4. Two instances share clock, reset and
//   stimulus: dut_hi (OUT_ACTIVE_LOW=0) and dut_lo (OUT_ACTIVE_LOW=1).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_decoder_2to4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  decoder_2to4_if bus_hi ();
  decoder_2to4_if bus_lo ();

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_hi)
  );

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lo)
  );

  logic [3:0] y_hi;
  logic [3:0] y_lo;
  assign y_hi = {bus_hi.Y3, bus_hi.Y2, bus_hi.Y1, bus_hi.Y0};
  assign y_lo = {bus_lo.Y3, bus_lo.Y2, bus_lo.Y1, bus_lo.Y0};

  always #5 clk = ~clk;

  // Both instances always see identical inputs.
  task automatic drive(input logic [1:0] a, input logic e);
    bus_hi.A = a;
    bus_hi.E = e;
    bus_lo.A = a;
    bus_lo.E = e;
  endtask

  task automatic test_reset();
    drive(2'b11, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (y_hi !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_async_hi: got %b expected %b", y_hi, 4'b0000);
    end
    tests_run++;
    if (y_lo !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL reset_async_lo: got %b expected %b", y_lo, 4'b1111);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (y_hi !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold_%0d: got %b expected %b", i, y_hi, 4'b0000);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (y_hi !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_hi: got %b expected %b", y_hi, 4'b1000);
    end
    tests_run++;
    if (y_lo !== 4'b0111) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_lo: got %b expected %b", y_lo, 4'b0111);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_tab [4];
    exp_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 1'b1);
      @(negedge clk);
      tests_run++;
      if (y_hi !== exp_tab[i]) begin
        tests_failed++;
        $display("[TB] FAIL sweep_hi_a%0d: got %b expected %b", i, y_hi, exp_tab[i]);
      end
      tests_run++;
      if (y_lo !== ~exp_tab[i]) begin
        tests_failed++;
        $display("[TB] FAIL sweep_lo_a%0d: got %b expected %b", i, y_lo, ~exp_tab[i]);
      end
    end
  endtask

  task automatic test_disable();
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 1'b0);
      @(negedge clk);
      tests_run++;
      if (y_hi !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL disable_a%0d: got %b expected %b", i, y_hi, 4'b0000);
      end
    end
    drive(2'b10, 1'b1);
    #1;
    tests_run++;
    if (y_hi !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL enable_before_edge: got %b expected %b", y_hi, 4'b0000);
    end
    @(negedge clk);
    tests_run++;
    if (y_hi !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL enable_after_edge: got %b expected %b", y_hi, 4'b0100);
    end
  endtask

  task automatic test_async_reset_mid();
    drive(2'b01, 1'b1);
    @(negedge clk);
    tests_run++;
    if (y_hi !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre: got %b expected %b", y_hi, 4'b0010);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (y_hi !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_async: got %b expected %b", y_hi, 4'b0000);
    end
    @(negedge clk);
    tests_run++;
    if (y_hi !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hold: got %b expected %b", y_hi, 4'b0000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (y_hi !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL midreset_resume: got %b expected %b", y_hi, 4'b0010);
    end
  endtask

  task automatic test_one_hot_random();
    logic [1:0] a;
    logic       e;
    logic [3:0] exp_y;
    // Previous step left A=01, E=1 registered.
    exp_y = 4'b0010;
    for (int i = 0; i < 1000; i++) begin
      a = 2'($urandom_range(0, 3));
      e = 1'($urandom_range(0, 1));
      drive(a, e);
      exp_y = e ? (4'b0001 << a) : 4'b0000;
      @(negedge clk);
      tests_run++;
      if (y_hi !== exp_y) begin
        tests_failed++;
        $display("[TB] FAIL random_hi_%0d: got %b expected %b", i, y_hi, exp_y);
      end
      tests_run++;
      if (y_lo !== ~exp_y) begin
        tests_failed++;
        $display("[TB] FAIL random_lo_%0d: got %b expected %b", i, y_lo, ~exp_y);
      end
      tests_run++;
      if ($countones(y_hi) > 1) begin
        tests_failed++;
        $display("[TB] FAIL one_hot_%0d: got %b expected at most one bit set", i, y_hi);
      end
    end
  endtask

  task automatic test_polarity_low();
    drive(2'b01, 1'b1);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (y_lo !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL pol1_reset: got %b expected %b", y_lo, 4'b1111);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (y_lo !== 4'b1101) begin
      tests_failed++;
      $display("[TB] FAIL pol1_select: got %b expected %b", y_lo, 4'b1101);
    end
    drive(2'b01, 1'b0);
    @(negedge clk);
    tests_run++;
    if (y_lo !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL pol1_disable: got %b expected %b", y_lo, 4'b1111);
    end
  endtask

  initial begin
    drive(2'b00, 1'b0);
    test_reset();
    test_sweep();
    test_disable();
    test_async_reset_mid();
    test_one_hot_random();
    test_polarity_low();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
